// File: rtl/pmp_pkg.sv
// Shared definitions for the NAPOT PMP scan controller: cfg byte layout,
// access encodings and controller states.
package pmp_pkg;

  localparam int CFG_R = 0;
  localparam int CFG_W = 1;
  localparam int CFG_X = 2;
  localparam int CFG_A_LSB = 3;
  localparam int CFG_A_MSB = 4;
  localparam int CFG_L = 7;

  localparam logic [1:0] A_OFF   = 2'b00;
  localparam logic [1:0] A_TOR   = 2'b01;
  localparam logic [1:0] A_NA4   = 2'b10;
  localparam logic [1:0] A_NAPOT = 2'b11;

  typedef enum logic [1:0] {ACC_READ = 2'd0, ACC_WRITE = 2'd1, ACC_EXEC = 2'd2} acc_type_e;
  typedef enum logic [1:0] {SZ_1B = 2'd0, SZ_2B = 2'd1, SZ_4B = 2'd2} acc_size_e;
  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_e;

  // Offset of the last byte from the first; the reserved size code acts as 4B.
  function automatic logic [1:0] size_last_off(input logic [1:0] sz);
    case (sz)
      SZ_1B:   size_last_off = 2'd0;
      SZ_2B:   size_last_off = 2'd1;
      default: size_last_off = 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/napot_region_match.sv
// Combinational NAPOT region test for the first and last byte of an access.
module napot_region_match
  import pmp_pkg::*;
(
  input  logic [31:0] pmpaddr_i,
  input  logic [31:0] addr_i,
  input  logic [1:0]  size_i,
  output logic        first_in_o,
  output logic        last_in_o
);

  logic [31:0] napot_mask;
  logic [33:0] base;
  logic [33:0] off_mask;
  logic        full_space;
  logic [32:0] last_byte;

  // x ^ (x+1) yields ones over the trailing-ones run plus the first zero: bits [k:0].
  assign napot_mask = pmpaddr_i ^ (pmpaddr_i + 32'd1);
  assign base       = {pmpaddr_i & ~napot_mask, 2'b00};
  assign off_mask   = {napot_mask, 2'b11};
  assign full_space = (&pmpaddr_i[28:0]) | (|base[33:32]);
  assign last_byte  = {1'b0, addr_i} + {31'd0, size_last_off(size_i)};

  // A carry into bit 32 never equals base[32] (zero unless full-space), so it misses.
  assign first_in_o = full_space | ((({2'b00, addr_i} ^ base) & ~off_mask) == 34'd0);
  assign last_in_o  = full_space | ((({1'b0, last_byte} ^ base) & ~off_mask) == 34'd0);

endmodule

// File: rtl/pmp_napot_scan_ctrl.sv
// Sequential PMP checker: scans NAPOT entries one per cycle through a single
// shared matcher; the lowest-numbered matching entry decides the response.
module pmp_napot_scan_ctrl
  import pmp_pkg::*;
#(
  parameter int N_ENTRIES = 8,
  parameter int IDX_W     = $clog2(N_ENTRIES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [31:0]             req_addr,
  input  logic [1:0]              req_size,
  input  logic [1:0]              req_type,
  input  logic                    req_priv_m,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic                    resp_allow,
  output logic                    resp_hit,
  output logic [IDX_W-1:0]        resp_idx,
  input  logic [32*N_ENTRIES-1:0] pmpaddr_flat,
  input  logic [8*N_ENTRIES-1:0]  pmpcfg_flat
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [31:0]        addr_q, addr_d;
  logic [1:0]         size_q, size_d, type_q, type_d;
  logic               priv_q, priv_d;
  logic               stg_vld_q, stg_vld_d, stg_full_q, stg_full_d, stg_part_q, stg_part_d;
  logic               stg_perm_q, stg_perm_d, stg_last_q, stg_last_d;
  logic [IDX_W-1:0]   stg_idx_q, stg_idx_d;
  logic               allow_q, allow_d, hit_q, hit_d;
  logic [IDX_W-1:0]   ridx_q, ridx_d;

  logic [31:0] sel_addr;
  logic        cfg_r, cfg_w, cfg_x, cfg_l, cfg_napot, eligible, perm, first_in, last_in;
  logic        last_entry;

  assign sel_addr  = pmpaddr_flat[{idx_q, 5'd0} +: 32];
  assign cfg_r     = pmpcfg_flat[{idx_q, 3'(CFG_R)}];
  assign cfg_w     = pmpcfg_flat[{idx_q, 3'(CFG_W)}];
  assign cfg_x     = pmpcfg_flat[{idx_q, 3'(CFG_X)}];
  assign cfg_l     = pmpcfg_flat[{idx_q, 3'(CFG_L)}];
  assign cfg_napot = ({pmpcfg_flat[{idx_q, 3'(CFG_A_MSB)}],
                       pmpcfg_flat[{idx_q, 3'(CFG_A_LSB)}]} == A_NAPOT);
  assign eligible  = cfg_napot & ~(priv_q & ~cfg_l);
  assign last_entry = (idx_q == IDX_W'(N_ENTRIES - 1));

  always_comb begin
    case (type_q)
      ACC_WRITE: perm = cfg_w;
      ACC_EXEC:  perm = cfg_x;
      default:   perm = cfg_r;
    endcase
  end

  napot_region_match u_match (
    .pmpaddr_i  (sel_addr),
    .addr_i     (addr_q),
    .size_i     (size_q),
    .first_in_o (first_in),
    .last_in_o  (last_in)
  );

  // The match result of entry idx is registered and decided one cycle later,
  // while the matcher already works on idx+1.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    addr_d     = addr_q;
    size_d     = size_q;
    type_d     = type_q;
    priv_d     = priv_q;
    stg_vld_d  = 1'b0;
    stg_idx_d  = stg_idx_q;
    stg_full_d = stg_full_q;
    stg_part_d = stg_part_q;
    stg_perm_d = stg_perm_q;
    stg_last_d = stg_last_q;
    allow_d    = allow_q;
    hit_d      = hit_q;
    ridx_d     = ridx_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          size_d  = req_size;
          type_d  = req_type;
          priv_d  = req_priv_m;
          idx_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        stg_vld_d  = 1'b1;
        stg_idx_d  = idx_q;
        stg_full_d = eligible & first_in & last_in;
        stg_part_d = eligible & (first_in ^ last_in);
        stg_perm_d = perm;
        stg_last_d = last_entry;
        if (!last_entry) idx_d = idx_q + 1'b1;
        if (stg_vld_q) begin
          if (stg_full_q || stg_part_q) begin
            hit_d     = 1'b1;
            allow_d   = stg_full_q & stg_perm_q;
            ridx_d    = stg_idx_q;
            stg_vld_d = 1'b0;
            state_d   = DONE;
          end else if (stg_last_q) begin
            hit_d     = 1'b0;
            allow_d   = priv_q;
            ridx_d    = '0;
            stg_vld_d = 1'b0;
            state_d   = DONE;
          end
        end
      end
      DONE: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      addr_q     <= '0;
      size_q     <= '0;
      type_q     <= '0;
      priv_q     <= 1'b0;
      stg_vld_q  <= 1'b0;
      stg_idx_q  <= '0;
      stg_full_q <= 1'b0;
      stg_part_q <= 1'b0;
      stg_perm_q <= 1'b0;
      stg_last_q <= 1'b0;
      allow_q    <= 1'b0;
      hit_q      <= 1'b0;
      ridx_q     <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      type_q     <= type_d;
      priv_q     <= priv_d;
      stg_vld_q  <= stg_vld_d;
      stg_idx_q  <= stg_idx_d;
      stg_full_q <= stg_full_d;
      stg_part_q <= stg_part_d;
      stg_perm_q <= stg_perm_d;
      stg_last_q <= stg_last_d;
      allow_q    <= allow_d;
      hit_q      <= hit_d;
      ridx_q     <= ridx_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == DONE);
  assign resp_allow = allow_q;
  assign resp_hit   = hit_q;
  assign resp_idx   = ridx_q;

endmodule

// File: tb/tb_pmp_napot_scan_ctrl.sv
// Directed bench for pmp_napot_scan_ctrl with a per-cycle reference model.
module tb_pmp_napot_scan_ctrl;

  localparam int N  = 8;
  localparam int IW = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            req_valid = 1'b0, req_ready;
  logic [31:0]     req_addr = '0;
  logic [1:0]      req_size = '0, req_type = '0;
  logic            req_priv_m = 1'b0;
  logic            resp_valid, resp_ready = 1'b1, resp_allow, resp_hit;
  logic [IW-1:0]   resp_idx;
  logic [32*N-1:0] pmpaddr_flat;
  logic [8*N-1:0]  pmpcfg_flat;
  logic [31:0]     pa [N];
  logic [7:0]      pc [N];

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < N; g++) begin : g_flat
    assign pmpaddr_flat[32*g +: 32] = pa[g];
    assign pmpcfg_flat[8*g +: 8]    = pc[g];
  end

  always #5 clk = ~clk;

  pmp_napot_scan_ctrl #(.N_ENTRIES(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_size(req_size), .req_type(req_type), .req_priv_m(req_priv_m),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_allow(resp_allow), .resp_hit(resp_hit), .resp_idx(resp_idx),
    .pmpaddr_flat(pmpaddr_flat), .pmpcfg_flat(pmpcfg_flat)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference: walk entries in order using plain region arithmetic.
  function automatic void model(input logic [31:0] a, input logic [1:0] sz, input logic [1:0] tp,
                                input logic pm, output logic al, output logic ht,
                                output logic [IW-1:0] ix, output int lat);
    logic   found = 1'b0;
    longint base, size, last, first;
    int     k;
    logic   full, fi, li, perm;
    al = pm; ht = 1'b0; ix = '0; lat = N + 1;
    first = longint'(a);
    last  = first + ((sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4) - 1;
    for (int i = 0; i < N; i++) begin
      if (!found && pc[i][4:3] == 2'b11 && !(pm && !pc[i][7])) begin
        k = 0;
        while (k < 32 && pa[i][k]) k++;
        base = ((longint'(pa[i]) >> (k + 1)) << (k + 1)) << 2;
        size = longint'(1) << (k + 3);
        full = (k >= 29) || (base >= 64'h1_0000_0000);
        fi = full || (first >= base && first < base + size);
        li = full || (last < 64'h1_0000_0000 && last >= base && last < base + size);
        perm = (tp == 2'd1) ? pc[i][1] : (tp == 2'd2) ? pc[i][2] : pc[i][0];
        if (fi || li) begin
          found = 1'b1;
          ht  = 1'b1;
          al  = fi && li && perm;
          ix  = IW'(i);
          lat = i + 2;
        end
      end
    end
  endfunction

  logic          m_busy = 1'b0;
  int            m_age = 0, m_lat = 0;
  logic          m_allow = 1'b0, m_hit = 1'b0;
  logic [IW-1:0] m_idx = '0;

  always @(negedge clk) begin : mon
    logic          ev, al, ht;
    logic [IW-1:0] ix;
    int            lt;
    if (rst) begin
      chk("rst_req_ready", req_ready, 1);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_allow", resp_allow, 0);
      chk("rst_resp_hit", resp_hit, 0);
      chk("rst_resp_idx", resp_idx, 0);
      m_busy <= 1'b0;
    end else begin
      ev = m_busy && (m_age >= m_lat);
      chk("cyc_req_ready", req_ready, !m_busy);
      chk("cyc_resp_valid", resp_valid, ev);
      if (ev) begin
        chk("cyc_resp_allow", resp_allow, m_allow);
        chk("cyc_resp_hit", resp_hit, m_hit);
        chk("cyc_resp_idx", resp_idx, m_idx);
      end
      if (!m_busy) begin
        if (req_valid) begin
          model(req_addr, req_size, req_type, req_priv_m, al, ht, ix, lt);
          m_allow <= al; m_hit <= ht; m_idx <= ix; m_lat <= lt;
          m_busy <= 1'b1; m_age <= 0;
        end
      end else if (ev && resp_ready) begin
        m_busy <= 1'b0;
      end else begin
        m_age <= m_age + 1;
      end
    end
  end

  task automatic clear_cfg();
    for (int i = 0; i < N; i++) begin pa[i] = '0; pc[i] = '0; end
  endtask

  task automatic do_req(input string nm, input logic [31:0] a, input logic [1:0] sz,
                        input logic [1:0] tp, input logic pm, input int hold,
                        input logic ea, input logic eh, input logic [IW-1:0] ei, input int elat);
    int n;
    bit got;
    @(posedge clk); #2;
    n = 0;
    while (!req_ready && n < 50) begin @(posedge clk); #2; n++; end
    chk({nm, "_ready"}, req_ready, 1);
    req_valid = 1'b1; req_addr = a; req_size = sz; req_type = tp; req_priv_m = pm;
    resp_ready = (hold == 0);
    @(posedge clk); #2;
    req_valid = 1'b0;
    n = 0; got = 1'b0;
    while (n <= 40) begin
      if (resp_valid) begin got = 1'b1; break; end
      @(posedge clk); #2; n++;
    end
    chk({nm, "_got_resp"}, got, 1);
    chk({nm, "_latency"}, n, elat);
    chk({nm, "_allow"}, resp_allow, ea);
    chk({nm, "_hit"}, resp_hit, eh);
    chk({nm, "_idx"}, resp_idx, ei);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #2;
      chk({nm, "_hold_valid"}, resp_valid, 1);
      chk({nm, "_hold_allow"}, resp_allow, ea);
      chk({nm, "_hold_ready"}, req_ready, 0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #2;
    chk({nm, "_after_valid"}, resp_valid, 0);
    chk({nm, "_after_ready"}, req_ready, 1);
  endtask

  initial begin
    clear_cfg();
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    pa[0] = 32'h0400_01FF; pc[0] = 8'h19;
    do_req("rd_hit",     32'h1000_0010, 2'd2, 2'd0, 1'b0, 0, 1, 1, 0, 2);
    do_req("wr_deny",    32'h1000_0010, 2'd2, 2'd1, 1'b0, 0, 0, 1, 0, 2);
    do_req("ex_deny",    32'h1000_0010, 2'd2, 2'd2, 1'b0, 0, 0, 1, 0, 2);
    do_req("straddle",   32'h1000_0FFE, 2'd2, 2'd0, 1'b0, 0, 0, 1, 0, 2);
    do_req("rsv_codes",  32'h1000_0FFC, 2'd3, 2'd3, 1'b0, 0, 1, 1, 0, 2);
    do_req("hold5",      32'h1000_0010, 2'd2, 2'd0, 1'b0, 5, 1, 1, 0, 2);

    clear_cfg(); pa[5] = 32'h0400_01FF; pc[5] = 8'h1F;
    do_req("e5_hit",     32'h1000_0100, 2'd2, 2'd0, 1'b0, 0, 1, 1, 5, 7);
    do_req("e5_miss_u",  32'h2000_0000, 2'd2, 2'd0, 1'b0, 0, 0, 0, 0, 9);
    do_req("e5_miss_m",  32'h2000_0000, 2'd2, 2'd0, 1'b1, 0, 1, 0, 0, 9);

    // Reset in the middle of a scan.
    @(posedge clk); #2;
    req_valid = 1'b1; req_addr = 32'h1000_0100; req_size = 2'd2; req_type = 2'd0; req_priv_m = 1'b0;
    @(posedge clk); #2;
    req_valid = 1'b0;
    repeat (2) begin @(posedge clk); #2; end
    rst = 1'b1;
    #1;
    chk("midscan_rst_ready", req_ready, 1);
    chk("midscan_rst_valid", resp_valid, 0);
    chk("midscan_rst_hit", resp_hit, 0);
    @(posedge clk); #2;
    rst = 1'b0;
    do_req("post_rst",   32'h1000_0100, 2'd2, 2'd0, 1'b0, 0, 1, 1, 5, 7);

    clear_cfg(); pa[0] = 32'h0400_01FF; pc[0] = 8'h19;
    do_req("m_unlocked", 32'h1000_0010, 2'd2, 2'd1, 1'b1, 0, 1, 0, 0, 9);
    pc[0] = 8'h99;
    do_req("m_locked_w", 32'h1000_0010, 2'd2, 2'd1, 1'b1, 0, 0, 1, 0, 2);
    do_req("m_locked_r", 32'h1000_0010, 2'd2, 2'd0, 1'b1, 0, 1, 1, 0, 2);

    clear_cfg();
    pa[1] = 32'h0400_01FF; pc[1] = 8'h18;
    pa[3] = 32'h0400_01FF; pc[3] = 8'h1F;
    do_req("priority",   32'h1000_0010, 2'd2, 2'd0, 1'b0, 0, 0, 1, 1, 3);
    pc[1] = 8'h0F;
    do_req("tor_ignored", 32'h1000_0010, 2'd2, 2'd0, 1'b0, 0, 1, 1, 3, 5);

    clear_cfg(); pa[0] = 32'h3FFF_FDFF; pc[0] = 8'h19;
    do_req("carry_part", 32'hFFFF_FFFE, 2'd2, 2'd0, 1'b0, 0, 0, 1, 0, 2);
    do_req("top_byte",   32'hFFFF_FFFF, 2'd0, 2'd0, 1'b0, 0, 1, 1, 0, 2);

    clear_cfg(); pa[2] = 32'hFFFF_FFFF; pc[2] = 8'h1C;
    do_req("full_carry_x", 32'hFFFF_FFFE, 2'd2, 2'd2, 1'b0, 0, 1, 1, 2, 4);
    do_req("full_r_deny",  32'h0000_0000, 2'd2, 2'd0, 1'b0, 0, 0, 1, 2, 4);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pmp_napot_scan_ctrl.md
Name: pmp_napot_scan_ctrl

Overview:
Sequential PMP checker that shares one NAPOT region matcher across N configured entries. It scans entries one per cycle in index order, and the lowest-numbered matching entry decides the outcome. It sits between the load/store/fetch request path and the memory port, returning allow/deny plus the deciding entry index. It trades latency for area: one matcher instead of N comparators.

Parameters:
N_ENTRIES, 8, number of PMP entries scanned (2..16)
IDX_W, $clog2(N_ENTRIES), width of entry index

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
req_valid  in  1  access request valid
req_ready  out  1  controller idle and able to accept a request
req_addr  in  32  byte address of access
req_size  in  2  0=1B, 1=2B, 2=4B (3 reserved, treated as 4B)
req_type  in  2  0=read, 1=write, 2=execute (3 treated as read)
req_priv_m  in  1  1=M-mode, 0=U-mode
resp_valid  out  1  result valid, held until accepted
resp_ready  in  1  consumer accepts result
resp_allow  out  1  access permitted
resp_hit  out  1  an entry (full or partial) decided the result
resp_idx  out  IDX_W  deciding entry index (0 when resp_hit=0)
pmpaddr_flat  in  32*N_ENTRIES  entry i at [32i+31:32i], holds address bits [33:2]
pmpcfg_flat  in  8*N_ENTRIES  entry i byte: bit0 R, bit1 W, bit2 X, bits4:3 A, bit7 L

Behaviour:
- Reset: state IDLE, req_ready=1, resp_valid=0, resp_allow=0, resp_hit=0, resp_idx=0, scan index=0. Reset mid-scan or mid-response aborts immediately with no response.
- IDLE: req_ready=1. On req_valid&req_ready, latch addr/size/type/priv, set idx=0, go to SCAN.
- SCAN: req_ready=0. Each cycle, evaluate entry idx with the shared matcher:
  - A=2'b11 (NAPOT) only. OFF, TOR and NA4 are treated as no-match.
  - In M-mode, entries with L=0 are skipped.
  - Full match (first and last byte inside region): record hit, allow = permission bit for the type, go to DONE.
  - Partial match (exactly one of first/last byte inside): record hit, allow=0, go to DONE.
  - Otherwise, if idx==N_ENTRIES-1: hit=0, allow=req_priv_m, go to DONE. Else idx++.
- Region math: let k = trailing-ones count of pmpaddr.
  - Size = 2^(k+3) bytes.
  - Base = (pmpaddr with bits [k:0] cleared) << 2, computed in 34 bits.
  - k>=29 or base>=2^32 truncation means the region covers the full 32-bit space.
  - Last byte = req_addr + (1<<req_size) - 1, computed in 33 bits. A carry out of bit 31 puts the last byte outside every region except full-space.
- DONE: resp_valid=1 with stable allow/hit/idx until resp_ready. On the handshake, go to IDLE; req_ready rises the following cycle.
- Latency: deciding entry i gives resp_valid i+2 cycles after the accept edge. No match gives N_ENTRIES+1 cycles.
- Throughput: one request in flight. No new accept while SCAN/DONE.
- Config must be stable while req_ready=0. Changes during a scan are undefined.

Decomposition:
- Shared package pmp_pkg holds:
  - cfg bit positions and A encodings (A_OFF/A_TOR/A_NA4/A_NAPOT)
  - access-type and size enums
  - state enum {IDLE, SCAN, DONE}
- One combinational sub-module napot_region_match: inputs pmpaddr, addr, size; outputs first_in, last_in. It is instantiated once and muxed by idx.

Test Plan:
- Entry0 pmpaddr=0x0400_01FF, cfg=0x19 (NAPOT, R only), others OFF; U read 4B at 0x1000_0010 -> allow=1, hit=1, idx=0, resp_valid 2 cycles after accept.
- Same config; U write 4B at 0x1000_0010 -> allow=0, hit=1, idx=0.
- Same config; U read 4B at 0x1000_0FFE (straddles end 0x1000_0FFF) -> allow=0, hit=1, idx=0.
- Only entry5 configured (region from test 1, cfg=0x1F) -> U read 4B at 0x1000_0100 gives idx=5, allow=1 at 7 cycles. U read at 0x2000_0000 gives allow=0, hit=0 at 9 cycles. M read at 0x2000_0000 gives allow=1, hit=0.
- Entry0 cfg=0x19, M write at 0x1000_0010 -> allow=1, hit=0 (L=0 skipped). Change cfg to 0x99 -> allow=0, hit=1, idx=0.
- Hold resp_ready=0 for 5 cycles -> resp_* stable, req_ready=0. Assert rst during SCAN -> all outputs at reset values same cycle; next request served normally.
